reset_seq: RTL

Reset sequencer between the Avalon memory-mapped soft-reset register and the system it resets. It merges three reset causes into one ordered reset sequence for the platform: a software request (the register's `reset_out`), a debounced board push-button, and PLL lock loss. Peripherals are released first and the ORCA core last, after programmable hold and gap intervals. It also issues a clear pulse so the soft-reset register can be returned to 0 by top-level wiring.

---
 rtl/reset_seq_pkg.sv | 30 +++
 rtl/key_debounce.sv | 65 ++++++
 rtl/reset_seq.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reset_seq_pkg
//  Description : Shared types and helpers for the reset sequencer: the
//                sequencer state encoding and the interval-counter width
//                helper used to size the HOLD/GAP counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

    // Sequencer states: both resets held, peripherals released, all released.
    typedef enum logic [1:0] {
        HOLD = 2'd0,
        PUP  = 2'd1,
        RUN  = 2'd2
    } seq_state_t;

    // Width of the shared HOLD/GAP interval counter.
    // It is sized for the larger interval and never narrower than one bit,
    // so that intervals of a single cycle still get a legal vector.
    function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
        int longest;
        int width;
        longest = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
        width   = $clog2(longest);
        return (width < 1) ? 1 : width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Synchronises the asynchronous active-low board button and
//                debounces it. A single-cycle press pulse is produced once the
//                button has been seen low for DEB_CYCLES consecutive cycles.
//                A further press is only accepted after the button has been
//                seen high again.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    // Counter must be able to hold DEB_CYCLES itself (saturation value).
    localparam int c_deb_w = $clog2(DEB_CYCLES + 1);
    localparam logic [c_deb_w-1:0] c_deb_max  = c_deb_w'(DEB_CYCLES);
    localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEB_CYCLES - 1);

    logic                r_key_meta;
    logic                r_key_s;
    logic [c_deb_w-1:0]  r_deb_cnt;
    logic                r_press;

    // Two-flop synchroniser; idles high (button released) out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_meta <= 1'b1;
            r_key_s    <= 1'b1;
        end else begin
            r_key_meta <= key_n;
            r_key_s    <= r_key_meta;
        end
    end

    // Count consecutive low cycles; clear on any high, hold at the limit so
    // a long press cannot wrap around and fire a second time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb_cnt <= '0;
        end else if (r_key_s) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt != c_deb_max) begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    // Press fires on the same edge the counter reaches the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_press <= 1'b0;
        end else begin
            r_press <= ~r_key_s & (r_deb_cnt == c_deb_last);
        end
    end

    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/reset_seq.sv
`default_nettype none
// ============================================================================
//  Module      : reset_seq
//  Description : Reset sequencer. Merges a software reset request, a
//                debounced push-button and PLL lock loss into one ordered
//                reset sequence: both resets are held for HOLD_CYCLES locked
//                cycles, peripherals are released, and the core follows
//                GAP_CYCLES later. A one-cycle soft_clr pulse acknowledges an
//                accepted software request so the request register can be
//                cleared.
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 8,
    parameter int DEB_CYCLES  = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic soft_req,
    input  logic key_n,
    input  logic pll_locked,
    output logic periph_reset,
    output logic core_reset,
    output logic soft_clr,
    output logic seq_busy
);

    localparam int c_cnt_w = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last  = c_cnt_w'(GAP_CYCLES - 1);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic r_lock_meta;
    logic r_locked_s;
    logic r_soft_q;
    logic w_press;
    logic w_soft_edge;
    logic w_trigger;

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_key_debounce (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_n),
        .press (w_press)
    );

    // PLL lock synchroniser; reads as unlocked out of reset so the hold
    // interval never starts before lock has actually been observed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_meta <= 1'b0;
            r_locked_s  <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_locked_s  <= r_lock_meta;
        end
    end

    // Previous soft request level; a request already high after reset is
    // therefore treated as a fresh edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_soft_q <= 1'b0;
        end else begin
            r_soft_q <= soft_req;
        end
    end

    assign w_soft_edge = soft_req & ~r_soft_q;

    // Any cause restarts the sequence; coincident causes merge into one.
    assign w_trigger = w_soft_edge | w_press | ~r_locked_s;

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    seq_state_t          r_state;
    seq_state_t          w_state_next;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_next;

    // State and interval counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HOLD;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and counter logic. A trigger always wins and restarts HOLD.
    // In HOLD a missing lock is itself a trigger, so the counter only
    // advances while locked.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (w_trigger) begin
            w_state_next = HOLD;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                HOLD: begin
                    if (r_cnt == c_hold_last) begin
                        w_state_next = PUP;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next   = r_cnt + 1'b1;
                    end
                end
                PUP: begin
                    if (r_cnt == c_gap_last) begin
                        w_state_next = RUN;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next   = r_cnt + 1'b1;
                    end
                end
                RUN: begin
                    w_state_next = RUN;
                    w_cnt_next   = '0;
                end
                default: begin
                    w_state_next = HOLD;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic r_periph_reset;
    logic r_core_reset;
    logic r_seq_busy;
    logic r_soft_clr;

    // Output flops are loaded with the decode of the next state, so they
    // always equal the decode of the state register while staying free of
    // any combinational path from the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_periph_reset <= 1'b1;
            r_core_reset   <= 1'b1;
            r_seq_busy     <= 1'b1;
            r_soft_clr     <= 1'b0;
        end else begin
            r_periph_reset <= (w_state_next == HOLD);
            r_core_reset   <= (w_state_next != RUN);
            r_seq_busy     <= (w_state_next != RUN);
            r_soft_clr     <= w_soft_edge;
        end
    end

    assign periph_reset = r_periph_reset;
    assign core_reset   = r_core_reset;
    assign seq_busy     = r_seq_busy;
    assign soft_clr     = r_soft_clr;

endmodule
`default_nettype wire
